// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button debouncer.
package btn_pkg;

  localparam int unsigned PressCountW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StArmPress,
    StPressed,
    StArmRelease
  } btn_state_e;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer that brings the raw button level into the clk domain.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/btn_debounce_counter.sv
// Debounced push-button with press/release strobes and a modulo-16 press counter.
// Optional auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce_counter
  import btn_pkg::*;
#(
  parameter int unsigned LOG2DEBOUNCE = 22,
  parameter int unsigned LOG2REPEAT   = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn,
  output logic                   btn_level,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic [PressCountW-1:0] press_count
);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned TimerW =
    (LOG2REPEAT > LOG2DEBOUNCE) ? LOG2REPEAT : LOG2DEBOUNCE;
  localparam logic [TimerW-1:0] RepeatLast = TimerW'((64'd1 << LOG2REPEAT) - 64'd1);
`else
  localparam int unsigned TimerW = LOG2DEBOUNCE;
`endif
  localparam logic [TimerW-1:0] DebounceLast = TimerW'((64'd1 << LOG2DEBOUNCE) - 64'd1);

  if (LOG2DEBOUNCE == 0 || LOG2DEBOUNCE > 31 || LOG2REPEAT == 0 || LOG2REPEAT > 31)
  begin : g_bad_param
    $error("btn_debounce_counter: LOG2DEBOUNCE/LOG2REPEAT must be in 1..31");
  end

  logic                   w_btn_s;
  btn_state_e             r_state;
  logic [TimerW-1:0]      r_timer;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic [PressCountW-1:0] r_count;

  btn_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (w_btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_timer   <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_count   <= '0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_btn_s) begin
            r_state <= StArmPress;
            r_timer <= '0;
          end
        end
        StArmPress: begin
          if (!w_btn_s) begin
            r_state <= StIdle;
          end else if (r_timer == DebounceLast) begin
            r_state <= StPressed;
            r_timer <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
            r_count <= r_count + 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StPressed: begin
          if (!w_btn_s) begin
            r_state <= StArmRelease;
            r_timer <= '0;
`ifdef BTN_AUTOREPEAT_EN
          end else if (r_timer == RepeatLast) begin
            r_timer <= '0;
            r_press <= 1'b1;
            r_count <= r_count + 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
`endif
          end
        end
        StArmRelease: begin
          // A rise here is bounce: return silently and restart the repeat period.
          if (w_btn_s) begin
            r_state <= StPressed;
            r_timer <= '0;
          end else if (r_timer == DebounceLast) begin
            r_state   <= StIdle;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign press_count   = r_count;

endmodule

// File: tb/tb_btn_debounce_counter.sv
// Self-checking bench: run-length reference model plus directed latency/bounce/wrap scenarios.
module tb_btn_debounce_counter;

  localparam int unsigned L2D     = 3;
  localparam int unsigned L2R     = 4;
  localparam int          Accept  = (1 << L2D) + 1;  // consecutive differing btn_s samples
  localparam int          RepLast = (1 << L2R) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [3:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic m_s1, m_s2, m_lvl, m_pp, m_rp;
  int   m_run, m_rep;
  logic [3:0] m_cnt;

  btn_debounce_counter #(
    .LOG2DEBOUNCE (L2D),
    .LOG2REPEAT   (L2R)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn           (btn),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pp = 0; m_rp = 0;
    m_run = 0; m_rep = 0; m_cnt = '0;
  endtask

  // One clock: drive inputs, advance model by the spec's rules, compare all outputs.
  task automatic tick(input logic b, input logic r);
    logic s;
    int   old_run;
    btn = b;
    rst = r;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = b;
      m_pp = 0;
      m_rp = 0;
      old_run = m_run;
      if (s != m_lvl) m_run++;
      else m_run = 0;
      if (m_run == Accept) begin
        m_lvl = s;
        m_run = 0;
        m_rep = 0;
        if (s) begin
          m_pp = 1;
          m_cnt++;
        end else begin
          m_rp = 1;
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      else if (m_lvl && s) begin
        if (old_run != 0) m_rep = 0;
        else if (m_rep == RepLast) begin
          m_rep = 0;
          m_pp = 1;
          m_cnt++;
        end else m_rep++;
      end
`endif
    end
    #1;
    check("btn_level", int'(btn_level), int'(m_lvl));
    check("press_pulse", int'(press_pulse), int'(m_pp));
    check("release_pulse", int'(release_pulse), int'(m_rp));
    check("press_count", int'(press_count), int'(m_cnt));
  endtask

  // Hold btn at b; return the 1-based tick on which the requested strobe appears (-1 on timeout).
  task automatic hold_until(input logic b, input bit want_press, output int idx);
    idx = -1;
    for (int i = 1; i <= 30; i++) begin
      tick(b, 1'b0);
      if ((want_press ? press_pulse : release_pulse) === 1'b1) begin
        idx = i;
        break;
      end
    end
  endtask

  initial begin
    int idx;
    int npulse;
    model_reset();

    // Reset state
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check("reset_level", int'(btn_level), 0);
    check("reset_count", int'(press_count), 0);
    tick(1'b0, 1'b0);

    // Clean press and clean release: latency 2^3+3 = 11
    hold_until(1'b1, 1'b1, idx);
    check("clean_press_latency", idx, 11);
    check("clean_press_count", int'(press_count), 1);
    check("clean_press_level", int'(btn_level), 1);
    tick(1'b1, 1'b0);
    check("single_press_pulse", int'(press_pulse), 0);
    hold_until(1'b0, 1'b0, idx);
    check("clean_release_latency", idx, 11);
    tick(1'b0, 1'b0);
    check("released_level", int'(btn_level), 0);

    // Bounce on press
    repeat (3) tick(1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
    hold_until(1'b1, 1'b1, idx);
    check("bounce_press_latency", idx, 11);
    check("bounce_press_count", int'(press_count), 2);
    repeat (4) tick(1'b1, 1'b0);

    // Bounce on release
    repeat (2) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check("bounce_release_level", int'(btn_level), 1);
    hold_until(1'b0, 1'b0, idx);
    check("bounce_release_latency", idx, 11);
    tick(1'b0, 1'b0);
    check("bounce_release_level_after", int'(btn_level), 0);

    // Counter wrap over 17 presses
    tick(1'b0, 1'b1);
    for (int p = 1; p <= 17; p++) begin
      repeat (12) tick(1'b1, 1'b0);
      repeat (12) tick(1'b0, 1'b0);
      if (p == 16) check("wrap_after_16", int'(press_count), 0);
    end
    check("wrap_after_17", int'(press_count), 1);

    // Reset mid ARM_PRESS with btn held
    repeat (6) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("midreset_level", int'(btn_level), 0);
    check("midreset_press", int'(press_pulse), 0);
    check("midreset_count", int'(press_count), 0);
    hold_until(1'b1, 1'b1, idx);
    check("post_reset_latency", idx, 11);

`ifdef BTN_AUTOREPEAT_EN
    // Auto-repeat: 60 more cycles held gives three repeats
    npulse = 1;
    repeat (60) begin
      tick(1'b1, 1'b0);
      if (press_pulse === 1'b1) npulse++;
    end
    check("repeat_pulses", npulse, 4);
    check("repeat_count", int'(press_count), 4);
`else
    npulse = 0;
    repeat (60) begin
      tick(1'b1, 1'b0);
      if (press_pulse === 1'b1) npulse++;
    end
    check("no_repeat_pulses", npulse, 0);
`endif

    // Random bursts of varied length with occasional resets
    for (int k = 0; k < 300; k++) begin
      logic b;
      int   len;
      b   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) tick(b, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
